// File: rtl/symbol_pair_fifo.sv
// symbol_pair_fifo: packs a serial bit stream into 2-bit symbols (MSB first)
// and buffers them in a show-ahead FIFO feeding the 2-bit sequence detector.
module symbol_pair_fifo #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              BitIn,
    input  logic              BitValid,
    input  logic              Flush,
    output logic [1:0]        SymbolOut,
    output logic              SymbolValid,
    input  logic              SymbolReady,
    output logic [ADDR_W:0]   Level,
    output logic              PartialPending,
    output logic              Overflow
);

    typedef enum logic {
        EMPTY_HALF = 1'b0,
        HAVE_MSB   = 1'b1
    } pack_state_t;

    localparam logic [ADDR_W:0]   LVL_ZERO = '0;
    localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    pack_state_t       state_q, state_d;
    logic              half_q, half_d;
    logic              push_s;
    logic [1:0]        push_sym_s;

    logic [1:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              overflow_q, overflow_d;

    logic              pop_s;
    logic              full_s;
    logic              wr_en_s;

    // Packing FSM next state: Flush wins over BitValid and drops the held half.
    always_comb begin
        state_d    = state_q;
        half_d     = half_q;
        push_s     = 1'b0;
        push_sym_s = 2'b00;
        if (Flush) begin
            state_d = EMPTY_HALF;
        end else if (BitValid) begin
            case (state_q)
                EMPTY_HALF: begin
                    half_d  = BitIn;
                    state_d = HAVE_MSB;
                end
                HAVE_MSB: begin
                    push_s     = 1'b1;
                    push_sym_s = {half_q, BitIn};
                    state_d    = EMPTY_HALF;
                end
                default: begin
                    state_d = EMPTY_HALF;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Packing FSM state and held MSB registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY_HALF;
            half_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
        end
    end

    // A pop frees a slot on the same edge, so push into a full FIFO is
    // accepted when it coincides with a pop.
    assign pop_s   = (level_q != LVL_ZERO) && SymbolReady;
    assign full_s  = (level_q == LVL_FULL);
    assign wr_en_s = push_s && (!full_s || pop_s);

    // FIFO bookkeeping next state: pointers, explicit level, sticky overflow.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, pop_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
        if (push_s && full_s && !pop_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // FIFO bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Symbol storage; cleared on reset so no stale symbol survives it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 2'b00;
            end
        end else if (wr_en_s) begin
            mem_q[wr_ptr_q] <= push_sym_s;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    // Show-ahead head of FIFO, forced to zero while empty.
    always_comb begin
        if (level_q != LVL_ZERO) begin
            SymbolOut = mem_q[rd_ptr_q];
        end else begin
            SymbolOut = 2'b00;
        end
    end

    assign SymbolValid    = (level_q != LVL_ZERO);
    assign Level          = level_q;
    assign PartialPending = (state_q == HAVE_MSB);
    assign Overflow       = overflow_q;

endmodule

// File: tb/tb_symbol_pair_fifo.sv
// Testbench for symbol_pair_fifo: directed vector table, hand sequences for
// overflow / full push-pop / wrap / reset, then randomized traffic against
// a queue-based reference model.
module tb_symbol_pair_fifo;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              BitIn = 1'b0;
    logic              BitValid = 1'b0;
    logic              Flush = 1'b0;
    logic              SymbolReady = 1'b0;
    logic [1:0]        SymbolOut;
    logic              SymbolValid;
    logic [ADDR_W:0]   Level;
    logic              PartialPending;
    logic              Overflow;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [1:0] mq[$];
    bit         m_have = 1'b0;
    bit         m_msb  = 1'b0;
    bit         m_ovf  = 1'b0;

    typedef struct {
        logic       rst;
        logic       bit_in;
        logic       bv;
        logic       flush;
        logic       rdy;
        logic [1:0] exp_out;
        logic       exp_v;
        logic [3:0] exp_lvl;
        logic       exp_pp;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[18];

    symbol_pair_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .BitIn(BitIn), .BitValid(BitValid), .Flush(Flush),
        .SymbolOut(SymbolOut), .SymbolValid(SymbolValid), .SymbolReady(SymbolReady),
        .Level(Level), .PartialPending(PartialPending), .Overflow(Overflow)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int r, input int b, input int v, input int f, input int y,
                                input int eo, input int ev, input int el, input int ep, input int eov);
        vec_t t;
        t.rst = 1'(r); t.bit_in = 1'(b); t.bv = 1'(v); t.flush = 1'(f); t.rdy = 1'(y);
        t.exp_out = 2'(eo); t.exp_v = 1'(ev); t.exp_lvl = 4'(el); t.exp_pp = 1'(ep); t.exp_ovf = 1'(eov);
        return t;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the spec's rules.
    task automatic model_step(input bit r, input bit b, input bit v, input bit f, input bit y);
        bit do_pop;
        bit do_push;
        logic [1:0] sym;
        if (r) begin
            mq.delete(); m_have = 1'b0; m_msb = 1'b0; m_ovf = 1'b0;
        end else begin
            do_pop  = (mq.size() > 0) && y;
            do_push = 1'b0;
            sym     = 2'b00;
            if (f) begin
                m_have = 1'b0;
            end else if (v) begin
                if (!m_have) begin
                    m_have = 1'b1; m_msb = b;
                end else begin
                    m_have = 1'b0; do_push = 1'b1; sym = {m_msb, b};
                end
            end
            if (do_push && mq.size() == DEPTH && !do_pop) begin
                m_ovf = 1'b1;
            end else begin
                if (do_pop) void'(mq.pop_front());
                if (do_push) mq.push_back(sym);
            end
        end
    endtask

    // Drive inputs for one edge, update the model, sample #1 after the edge.
    task automatic tick(input bit r, input bit b, input bit v, input bit f, input bit y);
        rst = r; BitIn = b; BitValid = v; Flush = f; SymbolReady = y;
        @(posedge clk);
        model_step(r, b, v, f, y);
        #1;
    endtask

    task automatic chk_model(input string tag);
        logic [1:0] eo;
        eo = (mq.size() > 0) ? mq[0] : 2'b00;
        chk({tag, ".out"},   8'(SymbolOut),      8'(eo));
        chk({tag, ".valid"}, 8'(SymbolValid),    8'(mq.size() > 0));
        chk({tag, ".level"}, 8'(Level),          8'(mq.size()));
        chk({tag, ".pp"},    8'(PartialPending), 8'(m_have));
        chk({tag, ".ovf"},   8'(Overflow),       8'(m_ovf));
    endtask

    task automatic push_sym(input logic [1:0] s, input bit y_second);
        tick(1'b0, s[1], 1'b1, 1'b0, 1'b0);
        tick(1'b0, s[0], 1'b1, 1'b0, y_second);
    endtask

    initial begin
        logic [1:0] drained;
        logic [1:0] sym;

        // Test plan 1, 2 and 5 as a vector table: inputs for one edge,
        // then outputs expected just after that edge.
        vecs[0]  = mk(1,0,0,0,0, 0,0,0,0,0);
        vecs[1]  = mk(0,1,1,0,0, 0,0,0,1,0);
        vecs[2]  = mk(0,1,1,0,0, 3,1,1,0,0);
        vecs[3]  = mk(0,0,1,0,0, 3,1,1,1,0);
        vecs[4]  = mk(0,0,1,0,0, 3,1,2,0,0);
        vecs[5]  = mk(0,1,1,0,0, 3,1,2,1,0);
        vecs[6]  = mk(0,0,1,0,0, 3,1,3,0,0);
        vecs[7]  = mk(0,0,0,0,1, 0,1,2,0,0);
        vecs[8]  = mk(0,0,0,0,1, 2,1,1,0,0);
        vecs[9]  = mk(0,0,0,0,1, 0,0,0,0,0);
        vecs[10] = mk(0,0,1,0,0, 0,0,0,1,0);
        vecs[11] = mk(0,1,1,0,0, 1,1,1,0,0);
        vecs[12] = mk(0,0,0,0,1, 0,0,0,0,0);
        vecs[13] = mk(0,1,1,0,0, 0,0,0,1,0);
        vecs[14] = mk(0,0,1,1,0, 0,0,0,0,0);
        vecs[15] = mk(0,0,1,0,0, 0,0,0,1,0);
        vecs[16] = mk(0,1,1,0,0, 1,1,1,0,0);
        vecs[17] = mk(0,0,0,0,1, 0,0,0,0,0);

        for (int i = 0; i < 18; i++) begin
            tick(vecs[i].rst, vecs[i].bit_in, vecs[i].bv, vecs[i].flush, vecs[i].rdy);
            chk($sformatf("vec%0d.out", i),   8'(SymbolOut),      8'(vecs[i].exp_out));
            chk($sformatf("vec%0d.valid", i), 8'(SymbolValid),    8'(vecs[i].exp_v));
            chk($sformatf("vec%0d.level", i), 8'(Level),          8'(vecs[i].exp_lvl));
            chk($sformatf("vec%0d.pp", i),    8'(PartialPending), 8'(vecs[i].exp_pp));
            chk($sformatf("vec%0d.ovf", i),   8'(Overflow),       8'(vecs[i].exp_ovf));
        end

        // Overflow: nine symbols into eight slots, then drain in order.
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            sym = 2'(i % 4);
            push_sym(sym, 1'b0);
        end
        chk("ovf.pre", 8'(Overflow), 8'd0);
        push_sym(2'b11, 1'b0);
        chk("ovf.level", 8'(Level), 8'd8);
        chk("ovf.flag",  8'(Overflow), 8'd1);
        for (int i = 0; i < 8; i++) begin
            drained = SymbolOut;
            sym = 2'(i % 4);
            chk($sformatf("ovf.drain%0d", i), 8'(drained), 8'(sym));
            tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            chk_model("ovf.drainm");
        end
        chk("ovf.sticky", 8'(Overflow), 8'd1);
        chk("ovf.empty",  8'(SymbolValid), 8'd0);

        // Full FIFO with simultaneous push and pop.
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            sym = 2'(i % 4);
            push_sym(sym, 1'b0);
        end
        chk("full.level", 8'(Level), 8'd8);
        push_sym(2'b10, 1'b1);
        chk("full.level2", 8'(Level), 8'd8);
        chk("full.ovf",    8'(Overflow), 8'd0);
        for (int i = 0; i < 8; i++) begin
            drained = SymbolOut;
            tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            chk_model("full.drain");
        end
        chk("full.last", 8'(drained), 8'd2);

        // Wrap: 20 symbols alternating 10/01 with SymbolReady held high.
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            sym = (i % 2 == 0) ? 2'b10 : 2'b01;
            push_sym(sym, 1'b1);
            chk_model("wrap.b");
            chk($sformatf("wrap.head%0d", i), 8'(SymbolOut), 8'(sym));
        end
        // Reset with Level=3 and PartialPending=1.
        push_sym(2'b11, 1'b0);
        push_sym(2'b01, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("rst.pre_level", 8'(Level), 8'd3);
        chk("rst.pre_pp",    8'(PartialPending), 8'd1);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("rst.out",   8'(SymbolOut), 8'd0);
        chk("rst.valid", 8'(SymbolValid), 8'd0);
        chk("rst.level", 8'(Level), 8'd0);
        chk("rst.pp",    8'(PartialPending), 8'd0);
        chk("rst.ovf",   8'(Overflow), 8'd0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 299) == 0),
                 1'($urandom),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 2) == 0));
            chk_model("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
